trace_dump_streamer: RTL and testbench

//  Capture-and-readout engine for the probe bundle (1+8+16 bits): records samples into an internal

---
 rtl/trace_dump_streamer.sv | 154 +++++++++++++++
 tb/tb_trace_dump_streamer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/trace_dump_streamer.sv
// Probe capture engine: circular RAM capture around a masked trigger, then framed byte readout.
// Latency: first header byte valid 1 cycle after capture completes; 1 byte/cycle with tx_ready high.
// Backpressure: tx_data/tx_last hold while tx_valid & !tx_ready; capture never stalls.
module trace_dump_streamer #(
  parameter int DEPTH    = 4096,
  parameter int PRE_TRIG = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        probe0,
  input  logic [7:0]  probe1,
  input  logic [15:0] probe2,
  input  logic        arm,
  input  logic [15:0] trig_mask,
  input  logic [15:0] trig_value,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        busy,
  output logic        done
);

  localparam int              AW        = $clog2(DEPTH);
  localparam int              GW        = AW + 3;
  localparam int              POST_N    = DEPTH - PRE_TRIG;
  localparam logic [AW-1:0]   PRE_LAST  = AW'(PRE_TRIG - 1);
  localparam logic [AW-1:0]   POST_LAST = AW'(POST_N - 1);
  localparam logic [GW-1:0]   GEN_TOTAL = GW'(DEPTH * 4 + 4);
  localparam logic [GW-1:0]   GEN_LAST  = GW'(DEPTH * 4 + 3);
  localparam logic [15:0]     DEPTH16   = 16'(DEPTH);

  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, HDR, DATA} state_t;

  state_t          state, state_nxt;
  logic [31:0]     mem [DEPTH];
  logic [31:0]     rd_word;
  logic [31:0]     word_q;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW-1:0]   pre_cnt, post_cnt;
  logic [GW-1:0]   gen_cnt;
  logic [7:0]      out_dat;
  logic            out_vld, out_last;
  logic            wr_en, trig_hit, load;
  logic [7:0]      byte_nxt;
  logic [31:0]     sample;

  assign sample   = {7'b0, probe0, probe1, probe2};
  assign trig_hit = ((probe2 ^ trig_value) & trig_mask) == 16'h0000;
  // A new byte enters the output register whenever it is empty or being drained.
  assign load     = ((state == HDR) || (state == DATA)) && (gen_cnt != GEN_TOTAL) &&
                    (!out_vld || tx_ready);

  assign tx_data  = out_dat;
  assign tx_valid = out_vld;
  assign tx_last  = out_last;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (arm) state_nxt = PRE;
      PRE:   if (pre_cnt == PRE_LAST) state_nxt = ARMED;
      ARMED: if (trig_hit) state_nxt = (POST_N == 1) ? HDR : POST;
      POST:  if (post_cnt == POST_LAST) state_nxt = HDR;
      HDR:   if (load && gen_cnt == GW'(3)) state_nxt = DATA;
      DATA:  if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-derived outputs: write strobe, busy flag and end-of-frame pulse.
  always_comb begin
    wr_en = (state == PRE) || (state == ARMED) || (state == POST);
    busy  = (state != IDLE);
    done  = (state == DATA) && out_vld && tx_ready && out_last;
  end

  // Sample RAM: one write per capture cycle, registered read every cycle.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= sample;
    rd_word <= mem[rd_ptr];
  end

  // Byte to load next: header constants first, then the current word MSB first.
  always_comb begin
    byte_nxt = 8'h00;
    if (gen_cnt < GW'(4)) begin
      case (gen_cnt[1:0])
        2'd0: byte_nxt = 8'hA5;
        2'd1: byte_nxt = 8'h5A;
        2'd2: byte_nxt = DEPTH16[15:8];
        default: byte_nxt = DEPTH16[7:0];
      endcase
    end else begin
      case (gen_cnt[1:0])
        2'd0: byte_nxt = word_q[31:24];
        2'd1: byte_nxt = word_q[23:16];
        2'd2: byte_nxt = word_q[15:8];
        default: byte_nxt = word_q[7:0];
      endcase
    end
  end

  // Capture pointers/counters and the output stage; the next word is prefetched
  // while the four bytes of the current one drain, so the RAM latency never shows.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pre_cnt  <= '0;
      post_cnt <= '0;
      gen_cnt  <= '0;
      word_q   <= '0;
      out_dat  <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
    end else begin
      if (state == IDLE && arm) begin
        wr_ptr  <= '0;
        pre_cnt <= '0;
        gen_cnt <= '0;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        // After the final write this points at the oldest sample.
        rd_ptr <= wr_ptr + 1'b1;
      end
      if (state == PRE) pre_cnt <= pre_cnt + 1'b1;
      if (state == ARMED && trig_hit) post_cnt <= AW'(1);
      if (state == POST) post_cnt <= post_cnt + 1'b1;
      if (load) begin
        gen_cnt  <= gen_cnt + 1'b1;
        out_dat  <= byte_nxt;
        out_vld  <= 1'b1;
        out_last <= (gen_cnt == GEN_LAST);
        if (gen_cnt[1:0] == 2'd3) begin
          word_q <= rd_word;
          rd_ptr <= rd_ptr + 1'b1;
        end
      end else if (out_vld && tx_ready) begin
        out_vld  <= 1'b0;
        out_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trace_dump_streamer.sv
// Directed bench: scoreboard of expected frame bytes, checked at each accepted byte.
// Probes follow a cycle counter restarted at each arm; stalls and bubbles checked every cycle.
// Covers trigger match, immediate trigger, random backpressure, arm while busy, reset abort, long wait.
module tb_trace_dump_streamer;

  localparam int TB_DEPTH = 16;
  localparam int TB_PRE   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        probe0;
  logic [7:0]  probe1;
  logic [15:0] probe2;
  logic        arm;
  logic [15:0] trig_mask, trig_value;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_last, busy, done;

  trace_dump_streamer #(.DEPTH(TB_DEPTH), .PRE_TRIG(TB_PRE)) dut (
    .clk(clk), .rst(rst), .probe0(probe0), .probe1(probe1), .probe2(probe2),
    .arm(arm), .trig_mask(trig_mask), .trig_value(trig_value),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  sb [$];
  logic [15:0] cnt;
  bit          rnd_ready;
  bit          in_frame;
  bit          prev_stall;
  logic [7:0]  prev_dat;
  logic        prev_last;
  int          acc_cnt = 0;
  int          done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [15:0] c);
    return {7'b0, c[0], ~c[7:0], c};
  endfunction

  task automatic drive_probes();
    probe0 = cnt[0];
    probe1 = ~cnt[7:0];
    probe2 = cnt;
  endtask

  task automatic push_frame(input logic [15:0] first);
    logic [15:0] dep;
    logic [31:0] w;
    dep = 16'(TB_DEPTH);
    sb.push_back(9'h0A5);
    sb.push_back(9'h05A);
    sb.push_back({1'b0, dep[15:8]});
    sb.push_back({1'b0, dep[7:0]});
    for (int k = 0; k < TB_DEPTH; k++) begin
      w = word_of(first + 16'(k));
      for (int b = 0; b < 4; b++)
        sb.push_back({(k == TB_DEPTH - 1) && (b == 3), w[31 - 8*b -: 8]});
    end
  endtask

  // One clock: check the settled outputs, then advance and drive the next inputs.
  task automatic cycle();
    logic [8:0] e;
    if (prev_stall) begin
      check("stall_valid", tx_valid, 1);
      check("stall_data", tx_data, prev_dat);
      check("stall_last", tx_last, prev_last);
    end
    if (in_frame) check("no_bubble", tx_valid, 1);
    if (tx_valid && tx_ready) begin
      if (sb.size() == 0) begin
        check("extra_byte", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check("byte", tx_data, e[7:0]);
        check("last", tx_last, e[8]);
        check("done_on_last", done, e[8]);
      end
      acc_cnt++;
    end else begin
      check("done_quiet", done, 0);
    end
    if (done) done_cnt++;
    if (tx_valid) in_frame = !(tx_ready && tx_last);
    prev_stall = tx_valid && !tx_ready;
    prev_dat   = tx_data;
    prev_last  = tx_last;
    @(posedge clk);
    #1;
    cnt = cnt + 16'd1;
    drive_probes();
    tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic arm_capture();
    cnt = 16'd0;
    drive_probes();
    arm = 1'b1;
    cycle();
    arm = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      cycle();
      n++;
    end
    check("frame_done", done_cnt, d0 + 1);
    check("sb_drained", sb.size(), 0);
    cycle();
    check("idle_after", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    rst = 1'b1; arm = 1'b0; tx_ready = 1'b1; rnd_ready = 1'b0;
    trig_mask = 16'hFFFF; trig_value = 16'h0010;
    cnt = 16'd0; drive_probes();
    in_frame = 1'b0; prev_stall = 1'b0; prev_dat = 8'h00; prev_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", tx_valid, 0);
    check("rst_last", tx_last, 0);
    check("rst_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    cycle();

    // 1: trigger on probe2 == 0x10, oldest stored sample 0x0C.
    push_frame(16'h000C);
    arm_capture();
    check("busy_capture", busy, 1);
    run_until_done(200);

    // 2: mask 0 triggers on the first armed cycle; samples 1..16 stored.
    trig_mask = 16'h0000;
    push_frame(16'h0001);
    arm_capture();
    run_until_done(200);

    // 3: random backpressure, same frame as test 1.
    trig_mask = 16'hFFFF;
    rnd_ready = 1'b1;
    push_frame(16'h000C);
    arm_capture();
    run_until_done(600);
    rnd_ready = 1'b0;
    tx_ready = 1'b1;

    // 4: arm pulses while armed and while streaming are ignored.
    push_frame(16'h000C);
    arm_capture();
    repeat (8) cycle();
    arm = 1'b1; cycle(); arm = 1'b0;
    base = acc_cnt;
    n = 0;
    while (acc_cnt < base + 30 && n < 200) begin cycle(); n++; end
    check("reach_data", acc_cnt - base, 30);
    arm = 1'b1; cycle(); arm = 1'b0;
    run_until_done(200);

    // 5: reset mid-stream aborts the frame; a fresh arm gives a full frame.
    push_frame(16'h000C);
    arm_capture();
    base = acc_cnt;
    n = 0;
    while (acc_cnt < base + 24 && n < 200) begin cycle(); n++; end
    check("rst_point", acc_cnt - base, 24);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_frame = 1'b0;
    prev_stall = 1'b0;
    sb.delete();
    check("abort_valid", tx_valid, 0);
    check("abort_busy", busy, 0);
    cycle();
    check("abort_valid_hold", tx_valid, 0);
    trig_mask = 16'h0000;
    push_frame(16'h0001);
    arm_capture();
    run_until_done(200);

    // 6: long wait for a late trigger; trigger sample lands at bytes 21..24.
    trig_mask = 16'hFFFF;
    trig_value = 16'h0400;
    push_frame(16'h03FC);
    arm_capture();
    for (int i = 0; i < 1000; i++) begin
      check("wait_busy", busy, 1);
      check("wait_valid", tx_valid, 0);
      cycle();
    end
    run_until_done(300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
